// File: rtl/commit_trace_sequencer_if.sv
// Commit-trace bus between the multi-retire core side and the single-commit checker side.
interface commit_trace_sequencer_if #(
    parameter int NRET  = 2,
    parameter int XLEN  = 32,
    parameter int REC_W = 4*XLEN+5+XLEN+1+1+6+XLEN+XLEN+1+XLEN
);
    logic [NRET-1:0]       in_valid;
    logic [NRET*REC_W-1:0] in_rec;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [REC_W-1:0]      out_rec;
    logic [32*XLEN-1:0]    out_regs;
    logic [31:0]           retired;
    logic                  err_overflow;
    logic                  err_lane;

    modport master (
        output in_valid, in_rec, out_ready,
        input  in_ready, out_valid, out_rec, out_regs, retired, err_overflow, err_lane
    );

    modport slave (
        input  in_valid, in_rec, out_ready,
        output in_ready, out_valid, out_rec, out_regs, retired, err_overflow, err_lane
    );
endinterface

// File: rtl/commit_trace_sequencer.sv
// Buffers up to NRET in-order commits per cycle, replays them one at a time to the
// checker together with the shadow register file as it stands after each commit.
module commit_trace_sequencer #(
    parameter int NRET  = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int REC_W = 4*XLEN+5+XLEN+1+1+6+XLEN+XLEN+1+XLEN
) (
    input  logic                            clock,
    input  logic                            reset,
    commit_trace_sequencer_if.slave         bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Field offsets from the LSB of a record
    localparam int TRAP_LSB  = XLEN;
    localparam int RDA_LSB   = 4*XLEN + 9;
    localparam int RDW_LSB   = 4*XLEN + 14;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] NRET_C  = CW'(NRET);

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [XLEN-1:0]  r_shadow [32];
    logic [31:0]      r_retired;
    logic             r_err_ovf;
    logic             r_err_lane;

    logic             w_any;
    logic             w_contig;
    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_npush;
    logic [NRET:0]    w_vinc;
    logic [REC_W-1:0] w_head;
    logic [4:0]       w_head_rd;
    logic [XLEN-1:0]  w_head_wdata;
    logic             w_head_wr;
    logic [32*XLEN-1:0] w_regs;

    // Input acceptance: contiguity check, space check and popcount of the valid lanes
    always_comb begin
        w_any      = |bus.in_valid;
        w_vinc     = {1'b0, bus.in_valid} + (NRET+1)'(1);
        w_contig   = (w_vinc[NRET-1:0] & bus.in_valid) == '0;
        w_in_ready = (DEPTH_C - r_count) >= NRET_C;
        w_push     = w_any && w_in_ready && w_contig;
        w_npush    = '0;
        for (int unsigned i = 0; i < NRET; i++) begin
            w_npush = w_npush + CW'(bus.in_valid[i]);
        end
    end

    // Head record decode and post-commit register view
    always_comb begin
        w_head       = (r_count != '0) ? r_mem[r_rptr] : '0;
        w_head_rd    = w_head[RDA_LSB +: 5];
        w_head_wdata = w_head[RDW_LSB +: XLEN];
        w_head_wr    = (r_count != '0) && (w_head_rd != 5'd0) && !w_head[TRAP_LSB];
        w_pop        = (r_count != '0) && bus.out_ready;
        w_regs       = '0;
        if (r_count != '0) begin
            for (int unsigned k = 0; k < 32; k++) begin
                w_regs[k*XLEN +: XLEN] = r_shadow[k];
            end
            if (w_head_wr) begin
                w_regs[w_head_rd*XLEN +: XLEN] = w_head_wdata;
            end
        end
    end

    // FIFO storage: valid lanes land at consecutive slots from the write pointer
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            for (int unsigned i = 0; i < NRET; i++) begin
                if (bus.in_valid[i]) begin
                    r_mem[r_wptr + PW'(i)] <= bus.in_rec[i*REC_W +: REC_W];
                end
            end
        end
    end

    // Pointers, occupancy, retire counter, shadow regfile and sticky errors
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_retired  <= '0;
            r_err_ovf  <= 1'b0;
            r_err_lane <= 1'b0;
            for (int unsigned k = 0; k < 32; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + w_npush[PW-1:0];
            end
            if (w_pop) begin
                r_rptr    <= r_rptr + PW'(1);
                r_retired <= r_retired + 32'd1;
                if (w_head_wr) begin
                    r_shadow[w_head_rd] <= w_head_wdata;
                end
            end
            r_count <= r_count + (w_push ? w_npush : '0) - CW'(w_pop);
            if (w_any && !w_in_ready) begin
                r_err_ovf <= 1'b1;
            end
            if (w_any && !w_contig) begin
                r_err_lane <= 1'b1;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = (r_count != '0);
    assign bus.out_rec      = w_head;
    assign bus.out_regs     = w_regs;
    assign bus.retired      = r_retired;
    assign bus.err_overflow = r_err_ovf;
    assign bus.err_lane     = r_err_lane;
endmodule

// File: tb/tb_commit_trace_sequencer.sv
// Directed bench for commit_trace_sequencer with NRET=2, DEPTH=8, XLEN=32.
module tb_commit_trace_sequencer;
    localparam int NRET  = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int REC_W = 8*XLEN + 14;

    localparam int PC_LSB   = 6*XLEN + 14;
    localparam int NPC_LSB  = 5*XLEN + 14;
    localparam int INST_LSB = 7*XLEN + 14;
    localparam int RDW_LSB  = 4*XLEN + 14;
    localparam int RDA_LSB  = 4*XLEN + 9;
    localparam int TRAP_LSB = XLEN;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    commit_trace_sequencer_if #(.NRET(NRET), .XLEN(XLEN), .REC_W(REC_W)) bus ();

    commit_trace_sequencer #(.NRET(NRET), .DEPTH(DEPTH), .XLEN(XLEN), .REC_W(REC_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [REC_W-1:0] mkrec(input logic [31:0] pc, input logic [4:0] rd,
                                               input logic [31:0] wdata, input logic trap);
        logic [REC_W-1:0] r;
        r = '0;
        r[INST_LSB +: 32] = pc ^ 32'h0000_0013;
        r[PC_LSB +: 32]   = pc;
        r[NPC_LSB +: 32]  = pc + 32'd4;
        r[RDW_LSB +: 32]  = wdata;
        r[RDA_LSB +: 5]   = rd;
        r[TRAP_LSB]       = trap;
        r[31:0]           = trap ? 32'd2 : 32'd0;
        return r;
    endfunction

    function automatic logic [31:0] regk(input logic [32*XLEN-1:0] v, input int k);
        return v[k*XLEN +: XLEN];
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.in_valid = '0;
        bus.in_rec = '0;
        bus.out_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
        vectors++; if (bus.retired !== 32'd0) begin miscompares++; $display("FAIL reset_retired got %0d want 0", bus.retired); end
        vectors++; if ({bus.err_overflow, bus.err_lane} !== 2'b00) begin miscompares++; $display("FAIL reset_errs got %b want 00", {bus.err_overflow, bus.err_lane}); end
        vectors++; if (bus.out_rec !== '0) begin miscompares++; $display("FAIL reset_out_rec got %h want 0", bus.out_rec); end
        vectors++; if (bus.out_regs !== '0) begin miscompares++; $display("FAIL reset_out_regs nonzero want 0"); end
    endtask

    task automatic test_single_lane();
        @(negedge clock);
        bus.out_ready = 1'b1;
        bus.in_valid  = 2'b01;
        bus.in_rec    = {{REC_W{1'b0}}, mkrec(32'h8000_0000, 5'd5, 32'h1234, 1'b0)};
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_no_bypass got %0b want 0", bus.out_valid); end
        @(negedge clock);
        bus.in_valid = '0;
        #1;
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_out_valid got %0b want 1", bus.out_valid); end
        vectors++; if (bus.out_rec[PC_LSB +: 32] !== 32'h8000_0000) begin miscompares++; $display("FAIL single_pc got %h want 80000000", bus.out_rec[PC_LSB +: 32]); end
        vectors++; if (regk(bus.out_regs, 5) !== 32'h1234) begin miscompares++; $display("FAIL single_reg5 got %h want 1234", regk(bus.out_regs, 5)); end
        vectors++; if (bus.retired !== 32'd0) begin miscompares++; $display("FAIL single_retired_before got %0d want 0", bus.retired); end
        @(negedge clock);
        #1;
        vectors++; if (bus.retired !== 32'd1) begin miscompares++; $display("FAIL single_retired got %0d want 1", bus.retired); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drained got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_dual_order();
        @(negedge clock);
        bus.out_ready = 1'b1;
        bus.in_valid  = 2'b11;
        bus.in_rec    = {mkrec(32'h104, 5'd7, 32'hB, 1'b0), mkrec(32'h100, 5'd6, 32'hA, 1'b0)};
        @(negedge clock);
        bus.in_valid = '0;
        #1;
        vectors++; if (bus.out_rec[PC_LSB +: 32] !== 32'h100) begin miscompares++; $display("FAIL dual_pc0 got %h want 100", bus.out_rec[PC_LSB +: 32]); end
        vectors++; if (regk(bus.out_regs, 6) !== 32'hA || regk(bus.out_regs, 7) !== 32'h0) begin miscompares++; $display("FAIL dual_regs0 got r6=%h r7=%h want A 0", regk(bus.out_regs, 6), regk(bus.out_regs, 7)); end
        @(negedge clock);
        #1;
        vectors++; if (bus.out_rec[PC_LSB +: 32] !== 32'h104) begin miscompares++; $display("FAIL dual_pc1 got %h want 104", bus.out_rec[PC_LSB +: 32]); end
        vectors++; if (regk(bus.out_regs, 6) !== 32'hA || regk(bus.out_regs, 7) !== 32'hB) begin miscompares++; $display("FAIL dual_regs1 got r6=%h r7=%h want A B", regk(bus.out_regs, 6), regk(bus.out_regs, 7)); end
        @(negedge clock);
        #1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.retired !== 32'd3) begin miscompares++; $display("FAIL dual_end got valid=%0b retired=%0d want 0 3", bus.out_valid, bus.retired); end
    endtask

    task automatic test_backpressure();
        logic [31:0] pc;
        @(negedge clock);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clock);
            #1;
            vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_%0d got %0b want 1", k, bus.in_ready); end
            pc = 32'h200 + 32'(8*k);
            bus.in_valid = 2'b11;
            bus.in_rec   = {mkrec(pc + 32'd4, 5'd0, 32'h0, 1'b0), mkrec(pc, 5'd0, 32'h0, 1'b0)};
        end
        @(negedge clock);
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready got %0b want 0", bus.in_ready); end
        bus.in_valid = 2'b11;
        bus.in_rec   = {mkrec(32'hDEAD_0004, 5'd1, 32'h5, 1'b0), mkrec(32'hDEAD_0000, 5'd1, 32'h5, 1'b0)};
        @(negedge clock);
        bus.in_valid = '0;
        #1;
        vectors++; if (bus.err_overflow !== 1'b1) begin miscompares++; $display("FAIL bp_err_overflow got %0b want 1", bus.err_overflow); end
        vectors++; if (bus.out_rec[PC_LSB +: 32] !== 32'h200) begin miscompares++; $display("FAIL bp_stable_pc got %h want 200", bus.out_rec[PC_LSB +: 32]); end
        bus.out_ready = 1'b1;
        for (int j = 1; j < 8; j++) begin
            @(negedge clock);
            #1;
            vectors++; if (bus.out_rec[PC_LSB +: 32] !== 32'h200 + 32'(4*j)) begin miscompares++; $display("FAIL bp_drain_%0d got %h want %h", j, bus.out_rec[PC_LSB +: 32], 32'h200 + 32'(4*j)); end
        end
        @(negedge clock);
        #1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.retired !== 32'd11) begin miscompares++; $display("FAIL bp_end got valid=%0b retired=%0d want 0 11", bus.out_valid, bus.retired); end
    endtask

    task automatic test_wrap();
        logic [31:0] q[$];
        logic [31:0] pc0;
        int n;
        int p;
        int cyc;
        do_reset();
        bus.out_ready = 1'b1;
        n = 0; p = 0; cyc = 0;
        while ((n < 20 || q.size() != 0) && cyc < 200) begin
            @(negedge clock);
            #1;
            cyc++;
            if (bus.out_valid) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++; $display("FAIL wrap_extra got pc %h want none", bus.out_rec[PC_LSB +: 32]);
                end else begin
                    if (bus.out_rec[PC_LSB +: 32] !== q[0]) begin miscompares++; $display("FAIL wrap_order got %h want %h", bus.out_rec[PC_LSB +: 32], q[0]); end
                    void'(q.pop_front());
                end
            end
            bus.in_valid = '0;
            if (n < 20 && bus.in_ready) begin
                pc0 = 32'h1000 + 32'(4*n);
                bus.in_rec = {mkrec(pc0 + 32'd4, 5'd0, 32'h0, 1'b0), mkrec(pc0, 5'd0, 32'h0, 1'b0)};
                if (p % 2 == 0) begin
                    bus.in_valid = 2'b11; q.push_back(pc0); q.push_back(pc0 + 32'd4); n += 2;
                end else begin
                    bus.in_valid = 2'b01; q.push_back(pc0); n += 1;
                end
                p++;
            end
        end
        bus.in_valid = '0;
        vectors++; if (cyc >= 200) begin miscompares++; $display("FAIL wrap_timeout got %0d cycles want <200", cyc); end
        @(negedge clock);
        #1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.retired !== 32'd20) begin miscompares++; $display("FAIL wrap_end got valid=%0b retired=%0d want 0 20", bus.out_valid, bus.retired); end
    endtask

    task automatic test_x0_trap_lane();
        @(negedge clock);
        bus.out_ready = 1'b1;
        bus.in_valid  = 2'b11;
        bus.in_rec    = {mkrec(32'h304, 5'd0, 32'hFFFF, 1'b0), mkrec(32'h300, 5'd3, 32'h33, 1'b0)};
        @(negedge clock);
        bus.in_valid = 2'b01;
        bus.in_rec   = {mkrec(32'h0, 5'd0, 32'h0, 1'b0), mkrec(32'h308, 5'd3, 32'h99, 1'b1)};
        #1;
        vectors++; if (regk(bus.out_regs, 3) !== 32'h33) begin miscompares++; $display("FAIL x0_reg3_first got %h want 33", regk(bus.out_regs, 3)); end
        @(negedge clock);
        bus.in_valid = '0;
        #1;
        vectors++; if (regk(bus.out_regs, 0) !== 32'h0) begin miscompares++; $display("FAIL x0_reg0 got %h want 0", regk(bus.out_regs, 0)); end
        vectors++; if (regk(bus.out_regs, 3) !== 32'h33) begin miscompares++; $display("FAIL x0_reg3 got %h want 33", regk(bus.out_regs, 3)); end
        @(negedge clock);
        #1;
        vectors++; if (bus.out_rec !== mkrec(32'h308, 5'd3, 32'h99, 1'b1)) begin miscompares++; $display("FAIL trap_passthru got %h want %h", bus.out_rec, mkrec(32'h308, 5'd3, 32'h99, 1'b1)); end
        vectors++; if (regk(bus.out_regs, 3) !== 32'h33) begin miscompares++; $display("FAIL trap_reg3 got %h want 33", regk(bus.out_regs, 3)); end
        @(negedge clock);
        #1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_regs !== '0) begin miscompares++; $display("FAIL trap_empty got valid=%0b want 0 and zero regs", bus.out_valid); end
        bus.in_valid = 2'b10;
        bus.in_rec   = {mkrec(32'h400, 5'd9, 32'h9, 1'b0), mkrec(32'h3FC, 5'd9, 32'h9, 1'b0)};
        @(negedge clock);
        bus.in_valid = '0;
        #1;
        vectors++; if (bus.err_lane !== 1'b1) begin miscompares++; $display("FAIL lane_err got %0b want 1", bus.err_lane); end
        vectors++; if (bus.out_valid !== 1'b0 || bus.err_overflow !== 1'b0) begin miscompares++; $display("FAIL lane_nopush got valid=%0b ovf=%0b want 0 0", bus.out_valid, bus.err_overflow); end
        vectors++; if (bus.retired !== 32'd23) begin miscompares++; $display("FAIL lane_retired got %0d want 23", bus.retired); end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        bus.out_ready = 1'b0;
        bus.in_valid  = 2'b11;
        bus.in_rec    = {mkrec(32'h504, 5'd4, 32'h44, 1'b0), mkrec(32'h500, 5'd4, 32'h40, 1'b0)};
        @(negedge clock);
        bus.in_valid = 2'b01;
        bus.in_rec   = {mkrec(32'h0, 5'd0, 32'h0, 1'b0), mkrec(32'h508, 5'd8, 32'h88, 1'b0)};
        @(negedge clock);
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        #1;
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_rec[PC_LSB +: 32] !== 32'h500) begin miscompares++; $display("FAIL mid_buffered got valid=%0b pc=%h want 1 500", bus.out_valid, bus.out_rec[PC_LSB +: 32]); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_state got valid=%0b ready=%0b want 0 1", bus.out_valid, bus.in_ready); end
        vectors++; if (bus.retired !== 32'd0) begin miscompares++; $display("FAIL mid_retired got %0d want 0", bus.retired); end
        vectors++; if ({bus.err_overflow, bus.err_lane} !== 2'b00) begin miscompares++; $display("FAIL mid_errs got %b want 00", {bus.err_overflow, bus.err_lane}); end
        bus.in_valid = 2'b01;
        bus.in_rec   = {mkrec(32'h0, 5'd0, 32'h0, 1'b0), mkrec(32'h600, 5'd0, 32'h0, 1'b0)};
        @(negedge clock);
        bus.in_valid = '0;
        #1;
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_regs !== '0) begin miscompares++; $display("FAIL mid_shadow_clear got valid=%0b r3=%h r4=%h want 1 0 0", bus.out_valid, regk(bus.out_regs, 3), regk(bus.out_regs, 4)); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        bus.in_valid = '0;
        bus.in_rec = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_lane();
        test_dual_order();
        test_backpressure();
        test_wrap();
        test_x0_trap_lane();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/commit_trace_sequencer.md
# commit_trace_sequencer

Parametrised commit-trace sequencer between a multi-retire core's trace outputs and the single-commit ISA checker. Accepts up to NRET retired instructions per cycle and buffers them in program order in a DEPTH-entry FIFO. Presents them one per handshake to the checker. Maintains a shadow architectural register file so the checker receives the full post-commit register state with each record.

## Interface
- NRET, 2: commit lanes per cycle (1..4); lane 0 is oldest.
- DEPTH, 8: FIFO entries; power of two, DEPTH >= 2*NRET.
- XLEN, 32: data/address width.
- REC_W, 4*XLEN+5+XLEN+1+1+6+XLEN+XLEN+1+XLEN: record width. Record fields, MSB first: inst, pc, next_pc, rd_wdata, rd_addr[4:0], mem_addr, mem_rvalid, mem_wvalid, mem_width[5:0], mem_rdata, mem_wdata, trap, cause.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  NRET  per-lane commit valid; must be contiguous from lane 0.
- in_rec  in  NRET*REC_W  per-lane record; lane i at [i*REC_W +: REC_W].
- in_ready  out  1  all NRET lanes can be accepted this cycle.
- out_valid  out  1  record presented to checker.
- out_ready  in  1  checker consumes presented record.
- out_rec  out  REC_W  oldest buffered record.
- out_regs  out  32*XLEN  register file after the presented commit; reg k at [k*XLEN +: XLEN].
- retired  out  32  count of records consumed at output; wraps.
- err_overflow  out  1  sticky: in_valid != 0 while in_ready = 0.
- err_lane  out  1  sticky: non-contiguous in_valid pattern.

## Operation
- Push: in_valid != 0 and in_ready=1 writes the valid lanes, in lane order, at consecutive write-pointer slots. The write pointer advances by popcount(in_valid).
- in_ready = (DEPTH - count) >= NRET, using the registered count only; a same-cycle pop does not raise in_ready.
- Dropped input: if in_valid != 0 and in_ready=0, nothing is written and err_overflow sets.
- Non-contiguous lanes (e.g. 2'b10): nothing is written, err_lane sets, and the record is dropped.
- Pop: out_valid = (count != 0). out_valid && out_ready advances the read pointer by 1 and increments retired.
- Shadow regfile: 32 x XLEN, all zero at reset. On a pop with rd_addr != 0 and trap=0, shadow[rd_addr] <= rd_wdata.
- out_regs: shadow with the presented record's rd write applied combinationally (same rules). Entry 0 is always 0.
- Traps: when trap=1 the record passes through unchanged and does not write rd.
- count update: count_next = count + pushed - popped, where popped is 0 or 1. Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Error flags are cleared only by reset. Operation continues normally after an error.

## Timing
- Reset values: count=0, pointers=0, shadow=0, out_valid=0, retired=0, err_overflow=0, err_lane=0, in_ready=1.
- out_rec and out_regs are 0 while empty.
- Latency: a record pushed in cycle N appears on out_valid/out_rec in cycle N+1 at the earliest. There is no combinational input-to-output bypass.
- Stability: while out_valid=1 and out_ready=0, out_rec and out_regs hold stable.
- Throughput: sustained output is 1 record/cycle. Input sustains NRET/cycle only while the FIFO drains.
- Simultaneous push and pop on a full-threshold boundary is legal; both take effect.
- Reset asserted mid-operation discards all buffered records at the next edge. No output handshake occurs in the reset cycle.

## Test plan
- Single lane: NRET=2, push lane0 {pc=0x80000000, rd=5, rd_wdata=0x1234}, out_ready=1 -> out_valid in the next cycle, out_regs reg5=0x1234, retired=1 one cycle later.
- Dual retire ordering: push lane0 pc=0x100 and lane1 pc=0x104 in one cycle -> out_rec.pc is 0x100, then 0x104 on consecutive cycles.
- Backpressure and overflow: DEPTH=8, out_ready=0, push 2 lanes/cycle for 4 cycles -> count=8, in_ready=0. A 5th push is dropped, err_overflow=1, and the FIFO contents are unchanged.
- Wrap-around: 20 pushes interleaved with pops, lane pattern alternating 2'b01/2'b11 -> output pc sequence strictly in input order, retired=20, count=0 at end.
- x0, trap, and lane error: a record with rd=0, rd_wdata=0xFFFF leaves reg0=0; a record with trap=1, rd=3 leaves reg3 unchanged; in_valid=2'b10 sets err_lane=1 with no push.
- Reset mid-stream: 3 records buffered, assert reset for one cycle -> out_valid=0, retired=0, all shadow regs 0, errors cleared, in_ready=1 next cycle.
